pulse_qualify: RTL
==================

# pulse_qualify

Upstream conditioning stage for `pulsestretch`. It takes a raw, asynchronous, possibly bouncing event line and synchronises it into the `clk` domain. It then debounces the line with a per-edge qualification FSM and emits clean single-cycle `rise_pulse` / `fall_pulse` strobes. `rise_pulse` drives `pulsestretch.in_pulse` directly. Rejected glitches are counted for debug.

## Interface
- `DEBOUNCE`, default 4: edges, after the entry edge, on which the synchronised input must hold the new level. Legal values are ≥1.
- `GCNT_W`, default 8: width of the glitch counter.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `raw_in`  in  1: asynchronous raw event line.
- `rise_pulse`  out  1: one-cycle strobe on a qualified 0→1 transition.
- `fall_pulse`  out  1: one-cycle strobe on a qualified 1→0 transition.
- `level`  out  1: debounced level.
- `glitch_cnt`  out  GCNT_W: number of aborted qualifications, saturating.

## Operation
- **Synchroniser.** `raw_in` passes through 2 flops, sync1 then s. The FSM samples only s.
- **FSM states.** IDLE_LO, DEB_HI, STABLE_HI, DEB_LO. `cnt` is $clog2(DEBOUNCE)+1 bits wide.
- **IDLE_LO:**
  - If s=1, go to DEB_HI with cnt←0.
  - Otherwise stay.
- **DEB_HI:**
  - If s=0, go to IDLE_LO and increment glitch_cnt.
  - Else if cnt==DEBOUNCE-1, go to STABLE_HI. Set level←1 and rise_pulse←1.
  - Else cnt←cnt+1.
- **STABLE_HI:**
  - If s=0, go to DEB_LO with cnt←0.
- **DEB_LO:** mirror of DEB_HI.
  - If s=1, go to STABLE_HI and increment glitch_cnt.
  - Terminal count goes to IDLE_LO. Set level←0 and fall_pulse←1.
- **Outputs.** All outputs are registered. Each pulse is high for exactly one cycle per qualified transition. `rise_pulse` and `fall_pulse` are never high together.
- **glitch_cnt** saturates at 2^GCNT_W-1 and does not wrap. It clears only on `rst`.
- **Level during debounce.** `level` holds its previous value throughout DEB_HI and DEB_LO.

## Timing
- **Reset value** (every edge where rst=1): sync1=0, s=0, state=IDLE_LO, cnt=0, level=0, rise_pulse=0, fall_pulse=0, glitch_cnt=0.
- **Qualification latency.** Let raw_in go high before edge N and stay high.
  - Edge N: sync1=1.
  - Edge N+1: s=1.
  - Edge N+2: enter DEB_HI.
  - Edge N+2+DEBOUNCE: rise_pulse=1 and level=1. With the default, this is edge N+6.
  - Edge N+3+DEBOUNCE: rise_pulse returns to 0.
- **Falling edge:** latency identical to rising.
- **Minimum accepted width.** s must be high on DEBOUNCE+1 consecutive edges. Anything shorter is a glitch: exactly one glitch_cnt increment per aborted DEB_* entry.
- **Reset mid-debounce.** The FSM returns to IDLE_LO and no pulse is emitted. If raw_in is still high after release, a fresh qualification runs. The first rst=0 edge counts as N.
- **Reset with raw_in held high:** outputs stay 0 during reset. After release, a normal rise qualifies.
- **Simultaneous abort and terminal count.** Not possible: the abort condition, s returning to the old level, takes priority over the terminal-count check.

## Structure
- **Shared package `pulse_pkg`:** FSM state encoding (ST_IDLE_LO, ST_DEB_HI, ST_STABLE_HI, ST_DEB_LO, 2 bits) and the default DEBOUNCE/GCNT_W constants.
- **Sub-module `sync_2ff`:** 2-flop synchroniser with synchronous active-high reset to 0. It is reusable elsewhere in the design.
- **Top:** FSM, debounce counter, output registers and glitch counter in `pulse_qualify`.

## Test plan
All scenarios use DEBOUNCE=4 and a 10 ns clock unless stated.
1. rst held, raw_in=1 → all outputs 0. rst released at edge R (first rst=0 edge) → rise_pulse=1 for exactly one cycle after edge R+6, and level=1 from then on.
2. raw_in 0→1 before edge N, held 20 cycles → single rise_pulse after edge N+6. Then raw_in→0 before edge M, held → single fall_pulse after edge M+6, level=0, glitch_cnt=0.
3. raw_in high for 2 cycles only → no rise_pulse, level stays 0, glitch_cnt=1.
4. Bounce: raw_in toggles 1,0,1,0,1,0 at one cycle each, then stays 1 → exactly one rise_pulse and glitch_cnt=3.
5. rst pulsed for one cycle while in DEB_HI, raw_in still 1 → no pulse before the reset. After release, one rise_pulse at R+6 and glitch_cnt=0.
6. 300 two-cycle glitches with GCNT_W=8 → glitch_cnt=255 and held. Repeat test 2 with DEBOUNCE=1 → rise_pulse after edge N+3.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse conditioning blocks: qualifier FSM encoding and
// default parameter values.
package pulse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE_LO   = 2'd0,
        ST_DEB_HI    = 2'd1,
        ST_STABLE_HI = 2'd2,
        ST_DEB_LO    = 2'd3
    } state_e;

    localparam int unsigned DEFAULT_DEBOUNCE = 4;
    localparam int unsigned DEFAULT_GCNT_W   = 8;

endpackage

// File: rtl/pulse_qualify_if.sv
// Event line in, qualified strobes / debounced level / glitch count out.
interface pulse_qualify_if
    import pulse_pkg::*;
#(
    parameter int unsigned GCNT_W = DEFAULT_GCNT_W
);

    logic              raw_in;
    logic              rise_pulse;
    logic              fall_pulse;
    logic              level;
    logic [GCNT_W-1:0] glitch_cnt;

    modport master (
        output raw_in,
        input  rise_pulse,
        input  fall_pulse,
        input  level,
        input  glitch_cnt
    );

    modport slave (
        input  raw_in,
        output rise_pulse,
        output fall_pulse,
        output level,
        output glitch_cnt
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, synchronous active-high reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic sync1_d, sync1_q;
    logic s_d, s_q;

    always_comb begin
        sync1_d = d_i;
        s_d     = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            s_q     <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            s_q     <= s_d;
        end
    end

    assign q_o = s_q;

endmodule

// File: rtl/pulse_qualify.sv
// Synchronises and debounces a raw event line, emitting one-cycle rise/fall strobes and
// counting aborted qualifications.
module pulse_qualify
    import pulse_pkg::*;
#(
    parameter int unsigned DEBOUNCE = DEFAULT_DEBOUNCE,
    parameter int unsigned GCNT_W   = DEFAULT_GCNT_W
) (
    input  logic            clk,
    input  logic            rst,
    pulse_qualify_if.slave  bus
);

    localparam int unsigned       CntW    = $clog2(DEBOUNCE) + 1;
    localparam logic [CntW-1:0]   CntMax  = CntW'(DEBOUNCE - 1);
    localparam logic [GCNT_W-1:0] GcntMax = '1;

    logic s;

    state_e            state_d, state_q;
    logic [CntW-1:0]   cnt_d, cnt_q;
    logic              level_d, level_q;
    logic              rise_d, rise_q;
    logic              fall_d, fall_q;
    logic [GCNT_W-1:0] glitch_cnt_d, glitch_cnt_q;
    logic              glitch_inc;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.raw_in),
        .q_o (s)
    );

    // Abort (s back at the old level) is checked before terminal count.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        level_d    = level_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        glitch_inc = 1'b0;
        unique case (state_q)
            ST_IDLE_LO: begin
                if (s) begin
                    state_d = ST_DEB_HI;
                    cnt_d   = '0;
                end
            end
            ST_DEB_HI: begin
                if (!s) begin
                    state_d    = ST_IDLE_LO;
                    glitch_inc = 1'b1;
                end else if (cnt_q == CntMax) begin
                    state_d = ST_STABLE_HI;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STABLE_HI: begin
                if (!s) begin
                    state_d = ST_DEB_LO;
                    cnt_d   = '0;
                end
            end
            ST_DEB_LO: begin
                if (s) begin
                    state_d    = ST_STABLE_HI;
                    glitch_inc = 1'b1;
                end else if (cnt_q == CntMax) begin
                    state_d = ST_IDLE_LO;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE_LO;
        endcase

        glitch_cnt_d = glitch_cnt_q;
        if (glitch_inc && (glitch_cnt_q != GcntMax)) begin
            glitch_cnt_d = glitch_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE_LO;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            glitch_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign bus.rise_pulse = rise_q;
    assign bus.fall_pulse = fall_q;
    assign bus.level      = level_q;
    assign bus.glitch_cnt = glitch_cnt_q;

endmodule
